// File: rtl/conversor_bcd_sequencial_pkg.sv
// Shared definitions for the iterative binary-to-BCD (double-dabble) converter.
package conversor_bcd_sequencial_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  localparam logic [3:0] BCD_ADD3   = 4'd3;
  localparam logic [3:0] BCD_THRESH = 4'd5;

endpackage

// File: rtl/conversor_bcd_sequencial_ajuste.sv
// bcd_digit_ajuste: combinational "if >= 5 then add 3" correction of one BCD digit.
module bcd_digit_ajuste
  import conversor_bcd_sequencial_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_THRESH) digit_o = digit_i + BCD_ADD3;
  end

endmodule

// File: rtl/conversor_bcd_sequencial.sv
// Iterative WIDTH-bit binary to DIGITS-digit packed BCD converter, one
// correct-and-shift step per clock, with start/busy/done handshake and overflow flag.
module conversor_bcd_sequencial
  import conversor_bcd_sequencial_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t              state_q;
  logic [WIDTH-1:0]    bin_q,  bin_d;
  logic [4*DIGITS-1:0] work_q, work_d, work_adj;
  logic [CW-1:0]       cnt_q;
  logic                sticky_q;
  logic                out_bit;
  logic                busy_q, done_q, ovf_q;
  logic [4*DIGITS-1:0] bcd_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_ajuste
    bcd_digit_ajuste u_ajuste (
      .digit_i (work_q[4*i +: 4]),
      .digit_o (work_adj[4*i +: 4])
    );
  end

  // The bit leaving the top digit is lost from the result and marks overflow.
  assign out_bit = work_adj[4*DIGITS-1];
  assign work_d  = {work_adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
  assign bin_d   = {bin_q[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bin_q    <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            bin_q    <= bin;
            work_q   <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= CW'(WIDTH);
            busy_q   <= 1'b1;
            state_q  <= ST_CONV;
          end
        end
        ST_CONV: begin
          bin_q    <= bin_d;
          work_q   <= work_d;
          sticky_q <= sticky_q | out_bit;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_q   <= work_d;
            ovf_q   <= sticky_q | out_bit;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_conversor_bcd_sequencial.sv
// Scoreboard bench for conversor_bcd_sequencial: three instances (8/3, 8/2, 16/5).
module tb_conversor_bcd_sequencial;

  typedef struct {
    logic [39:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        st [3];
  logic [15:0] bi [3];

  logic        busy0, done0, ovf0;
  logic [11:0] bcd0;
  logic        busy1, done1, ovf1;
  logic [7:0]  bcd1;
  logic        busy2, done2, ovf2;
  logic [19:0] bcd2;

  conversor_bcd_sequencial #(.WIDTH(8), .DIGITS(3)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .bin(bi[0][7:0]),
    .busy(busy0), .done(done0), .bcd(bcd0), .overflow(ovf0));
  conversor_bcd_sequencial #(.WIDTH(8), .DIGITS(2)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .bin(bi[1][7:0]),
    .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1));
  conversor_bcd_sequencial #(.WIDTH(16), .DIGITS(5)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .bin(bi[2]),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2));

  exp_t q0[$], q1[$], q2[$];
  logic [39:0] hold_b [3];
  logic        hold_o [3];
  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [39:0] act, logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int qsize(int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic int width_of(int k);
    return (k == 2) ? 16 : 8;
  endfunction

  function automatic logic busy_of(int k);
    case (k)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  // Reference: decimal digits by division; overflow if anything remains above the top digit.
  function automatic logic [40:0] ref_bcd(int unsigned v, int digits);
    logic [39:0] r = '0;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return {(v != 0), r};
  endfunction

  task automatic mon(int k, logic dn, logic bz, logic [39:0] b, logic ov);
    exp_t e;
    if (dn) begin
      chk($sformatf("u%0d_busy_with_done", k), {39'b0, bz}, 40'd0);
      if (qsize(k) == 0) begin
        checks++;
        errors++;
        $display("FAIL u%0d_unexpected_done actual=1 required=0 (t=%0t)", k, $time);
      end else begin
        case (k)
          0: e = q0.pop_front();
          1: e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        chk($sformatf("u%0d_bcd", k), b, e.bcd);
        chk($sformatf("u%0d_overflow", k), {39'b0, ov}, {39'b0, e.ovf});
        chk($sformatf("u%0d_latency", k), 40'(cyc), 40'(e.cyc));
        hold_b[k] = e.bcd;
        hold_o[k] = e.ovf;
      end
    end else begin
      chk($sformatf("u%0d_hold_bcd", k), b, hold_b[k]);
      chk($sformatf("u%0d_hold_ovf", k), {39'b0, ov}, {39'b0, hold_o[k]});
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, done0, busy0, {28'b0, bcd0}, ovf0);
      mon(1, done1, busy1, {32'b0, bcd1}, ovf1);
      mon(2, done2, busy2, {20'b0, bcd2}, ovf2);
    end
  end

  task automatic push(int k, logic [39:0] eb, logic eo);
    exp_t e;
    e.bcd = eb;
    e.ovf = eo;
    e.cyc = cyc + width_of(k);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic issue(int k, int v, logic [39:0] eb, logic eo, bit keep_start);
    @(negedge clk);
    st[k] = 1'b1;
    bi[k] = 16'(v);
    @(posedge clk);
    #1;
    if (!keep_start) st[k] = 1'b0;
    chk($sformatf("u%0d_busy_after_accept", k), {39'b0, busy_of(k)}, 40'd1);
    push(k, eb, eo);
  endtask

  task automatic wait_idle(int k);
    int n = 0;
    while (qsize(k) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (qsize(k) != 0) begin
      checks++;
      errors++;
      $display("FAIL u%0d_done_timeout actual=%0d_pending required=0", k, qsize(k));
      case (k)
        0: q0.delete();
        1: q1.delete();
        default: q2.delete();
      endcase
    end
  endtask

  initial begin
    logic [40:0] r;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0;
      bi[k] = '0;
      hold_b[k] = '0;
      hold_o[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("reset_busy", {39'b0, busy0}, 40'd0);
    chk("reset_done", {39'b0, done0}, 40'd0);
    chk("reset_bcd", {28'b0, bcd0}, 40'd0);
    chk("reset_ovf", {39'b0, ovf0}, 40'd0);
    rst = 1'b0;

    issue(0, 255, 40'h255, 1'b0, 1'b0); wait_idle(0);
    issue(0, 0,   40'h000, 1'b0, 1'b0); wait_idle(0);
    issue(0, 99,  40'h099, 1'b0, 1'b0); wait_idle(0);

    issue(1, 200, 40'h00, 1'b1, 1'b0); wait_idle(1);
    issue(1, 99,  40'h99, 1'b0, 1'b0); wait_idle(1);

    // Second start at T3 must be ignored.
    issue(0, 128, 40'h128, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    st[0] = 1'b1;
    bi[0] = 16'd7;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    wait_idle(0);
    repeat (12) @(posedge clk);

    // Start held high: accepted again in the done cycle.
    issue(0, 45, 40'h045, 1'b0, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    bi[0] = 16'd67;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    push(0, 40'h067, 1'b0);
    wait_idle(0);

    // Reset at T4 discards the conversion.
    issue(0, 200, 40'h200, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", {39'b0, busy0}, 40'd0);
    chk("midrst_done", {39'b0, done0}, 40'd0);
    chk("midrst_bcd", {28'b0, bcd0}, 40'd0);
    chk("midrst_ovf", {39'b0, ovf0}, 40'd0);
    void'(q0.pop_back());
    hold_b[0] = '0;
    hold_o[0] = 1'b0;
    hold_b[1] = '0;
    hold_o[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue(0, 200, 40'h200, 1'b0, 1'b0); wait_idle(0);

    issue(2, 65535, 40'h65535, 1'b0, 1'b0); wait_idle(2);
    issue(2, 10000, 40'h10000, 1'b0, 1'b0); wait_idle(2);

    for (int v = 0; v < 256; v++) begin
      r = ref_bcd(v, 3);
      issue(0, v, r[39:0], r[40], 1'b0);
      wait_idle(0);
    end
    for (int v = 0; v < 256; v += 17) begin
      r = ref_bcd(v, 2);
      issue(1, v, r[39:0], r[40], 1'b0);
      wait_idle(1);
    end

    repeat (20) @(posedge clk);
    chk("q0_empty", 40'(q0.size()), 40'd0);
    chk("q1_empty", 40'(q1.size()), 40'd0);
    chk("q2_empty", 40'(q2.size()), 40'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
